// File: rtl/wordle_pkg.sv
// Shared types and constants for the Wordle guess controller and its scorer.
package wordle_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_EDIT,
      ST_DICT,
      ST_GREEN,
      ST_YELLOW,
      ST_REPORT,
      ST_DONE
   } state_t;

   localparam logic [7:0] ALPHA_FIRST = 8'h41;
   localparam logic [7:0] ALPHA_LAST  = 8'h5A;

   localparam logic [1:0] GRAY   = 2'b00;
   localparam logic [1:0] YELLOW = 2'b01;
   localparam logic [1:0] GREEN  = 2'b10;

   // Five ASCII letters; element 0 is the leftmost letter on screen.
   typedef logic [4:0][7:0] word_t;

   localparam word_t WORD_RESET = {5{ALPHA_FIRST}};

   function automatic logic [7:0] letter_up(input logic [7:0] l);
      return (l == ALPHA_LAST) ? ALPHA_FIRST : l + 8'd1;
   endfunction

   function automatic logic [7:0] letter_down(input logic [7:0] l);
      return (l == ALPHA_FIRST) ? ALPHA_LAST : l - 8'd1;
   endfunction

endpackage

// File: rtl/wordle_guess_ctrl_scorer.sv
// Fixed-latency two-pass scorer: 5 green cycles, then 25 yellow cycles
// walking every (guess i, answer j) pair; result is committed only at the end.
module wordle_scorer
   import wordle_pkg::*;
(
   input  logic        Clk,
   input  logic        reset,
   input  logic        start,
   input  logic        clear,
   input  logic [39:0] guess,
   input  logic [39:0] answer,
   output logic        green_done,
   output logic        done,
   output logic        all_green,
   output logic [9:0]  result
);

   word_t       g_w;
   word_t       a_w;
   logic        active;
   logic        yel_phase;
   logic [2:0]  i;
   logic [2:0]  j;
   logic [4:0]  used, grn, yel;
   logic [4:0]  used_nxt, grn_nxt, yel_nxt;

   assign g_w = guess;
   assign a_w = answer;

   function automatic logic [9:0] pack_result(input logic [4:0] gm, input logic [4:0] ym);
      logic [9:0] r;
      r = '0;
      for (int k = 0; k < 5; k++)
         r[2*k +: 2] = gm[k] ? GREEN : (ym[k] ? YELLOW : GRAY);
      return r;
   endfunction

   always_comb begin
      grn_nxt  = grn;
      yel_nxt  = yel;
      used_nxt = used;
      if (active) begin
         if (!yel_phase) begin
            if (g_w[i] == a_w[i]) begin
               grn_nxt[i]  = 1'b1;
               used_nxt[i] = 1'b1;
            end
         end else if (!grn[i] && !yel[i] && !used[j] && (g_w[i] == a_w[j])) begin
            // yel[i] already set means an earlier j claimed this letter
            yel_nxt[i]  = 1'b1;
            used_nxt[j] = 1'b1;
         end
      end
   end

   assign green_done = active && !yel_phase && (i == 3'd4);
   assign done       = active && yel_phase && (i == 3'd4) && (j == 3'd4);
   assign all_green  = &grn;

   always_ff @(posedge Clk or posedge reset) begin
      if (reset) begin
         active    <= 1'b0;
         yel_phase <= 1'b0;
         i         <= '0;
         j         <= '0;
         used      <= '0;
         grn       <= '0;
         yel       <= '0;
         result    <= '0;
      end else begin
         if (clear)
            result <= '0;
         if (start) begin
            active    <= 1'b1;
            yel_phase <= 1'b0;
            i         <= '0;
            j         <= '0;
            used      <= '0;
            grn       <= '0;
            yel       <= '0;
         end else if (active) begin
            grn  <= grn_nxt;
            yel  <= yel_nxt;
            used <= used_nxt;
            if (!yel_phase) begin
               if (i == 3'd4) begin
                  yel_phase <= 1'b1;
                  i         <= '0;
                  j         <= '0;
               end else begin
                  i <= i + 3'd1;
               end
            end else if (j == 3'd4) begin
               j <= '0;
               if (i == 3'd4) begin
                  active <= 1'b0;
                  result <= pack_result(grn_nxt, yel_nxt);
               end else begin
                  i <= i + 3'd1;
               end
            end else begin
               j <= j + 3'd1;
            end
         end
      end
   end

endmodule

// File: rtl/wordle_guess_ctrl.sv
// Wordle game sequencer: guess editing, optional dictionary check
// (WORDLE_DICT_CHECK_EN), scoring handoff and win/lose accounting.
//
// state     | meaning
// ----------+----------------------------------------------
// ST_IDLE   | waiting for C to start a game
// ST_EDIT   | buttons edit guess_word / cursor, C submits
// ST_DICT   | dict_req held until dict_ack (macro only)
// ST_GREEN  | scorer exact-position pass, 5 cycles
// ST_YELLOW | scorer misplaced-letter pass, 25 cycles
// ST_REPORT | result published, guess counted
// ST_DONE   | win or lose held until C
module wordle_guess_ctrl
   import wordle_pkg::*;
#(
   parameter int MAX_GUESSES = 6
) (
   input  logic        Clk,
   input  logic        reset,
   input  logic        U,
   input  logic        D,
   input  logic        L,
   input  logic        R,
   input  logic        C,
   input  logic [39:0] answer,
   output logic        dict_req,
   output logic [39:0] dict_word,
   input  logic        dict_ack,
   input  logic        dict_hit,
   output logic [39:0] guess_word,
   output logic [2:0]  cursor,
   output logic [9:0]  result,
   output logic        result_valid,
   output logic        invalid_word,
   output logic [2:0]  guess_count,
   output logic        busy,
   output logic        win,
   output logic        lose
);

   state_t state, state_nxt;
   word_t  guess_q;
   word_t  ans_q;
   logic   score_start, score_clear;
   logic   green_done, score_done, all_green;

   assign guess_word = guess_q;
   assign dict_word  = guess_q;

   wordle_scorer u_scorer (
      .Clk        (Clk),
      .reset      (reset),
      .start      (score_start),
      .clear      (score_clear),
      .guess      (guess_q),
      .answer     (ans_q),
      .green_done (green_done),
      .done       (score_done),
      .all_green  (all_green),
      .result     (result)
   );

   always_ff @(posedge Clk or posedge reset) begin
      if (reset)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (C) state_nxt = ST_EDIT;
`ifdef WORDLE_DICT_CHECK_EN
         ST_EDIT:   if (C) state_nxt = ST_DICT;
         ST_DICT:   if (dict_ack) state_nxt = dict_hit ? ST_GREEN : ST_EDIT;
`else
         ST_EDIT:   if (C) state_nxt = ST_GREEN;
`endif
         ST_GREEN:  if (green_done) state_nxt = ST_YELLOW;
         ST_YELLOW: if (score_done) state_nxt = ST_REPORT;
         ST_REPORT: state_nxt = (win || lose) ? ST_DONE : ST_EDIT;
         ST_DONE:   if (C) state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      busy         = (state == ST_DICT) || (state == ST_GREEN) ||
                     (state == ST_YELLOW) || (state == ST_REPORT);
      result_valid = (state == ST_REPORT);
      score_clear  = ((state == ST_IDLE) || (state == ST_DONE)) && C;
`ifdef WORDLE_DICT_CHECK_EN
      dict_req     = (state == ST_DICT);
      invalid_word = (state == ST_DICT) && dict_ack && !dict_hit;
      score_start  = (state == ST_DICT) && dict_ack && dict_hit;
`else
      dict_req     = 1'b0;
      invalid_word = 1'b0;
      score_start  = (state == ST_EDIT) && C;
`endif
   end

`ifndef WORDLE_DICT_CHECK_EN
   logic unused_dict;
   assign unused_dict = dict_ack ^ dict_hit;
`endif

   // Game datapath: editing, answer latch and outcome flags.
   always_ff @(posedge Clk or posedge reset) begin
      if (reset) begin
         guess_q     <= WORD_RESET;
         cursor      <= '0;
         ans_q       <= '0;
         guess_count <= '0;
         win         <= 1'b0;
         lose        <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (C) begin
                  guess_q     <= WORD_RESET;
                  cursor      <= '0;
                  guess_count <= '0;
                  win         <= 1'b0;
                  lose        <= 1'b0;
                  if (state == ST_IDLE)
                     ans_q <= answer;
               end
            end
            ST_EDIT: begin
               if (C) begin
                  // submit: letters and cursor freeze during scoring
               end else if (U) begin
                  guess_q[cursor] <= letter_up(guess_q[cursor]);
               end else if (D) begin
                  guess_q[cursor] <= letter_down(guess_q[cursor]);
               end else if (L) begin
                  if (cursor != 3'd0) cursor <= cursor - 3'd1;
               end else if (R) begin
                  if (cursor != 3'd4) cursor <= cursor + 3'd1;
               end
            end
            ST_YELLOW: begin
               if (score_done) begin
                  guess_count <= guess_count + 3'd1;
                  win         <= all_green;
                  lose        <= !all_green && (guess_count == 3'(MAX_GUESSES - 1));
               end
            end
            ST_REPORT: begin
               if (!(win || lose)) begin
                  guess_q <= WORD_RESET;
                  cursor  <= '0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_wordle_guess_ctrl.sv
// Self-checking bench for wordle_guess_ctrl: directed edits plus random games
// scored against a letter-counting reference model.
module tb_wordle_guess_ctrl;

   localparam int MAX = 6;

   logic        Clk = 1'b0;
   logic        reset;
   logic        U, D, L, R, C;
   logic [39:0] answer;
   logic        dict_req;
   logic [39:0] dict_word;
   logic        dict_ack, dict_hit;
   logic [39:0] guess_word;
   logic [2:0]  cursor;
   logic [9:0]  result;
   logic        result_valid, invalid_word;
   logic [2:0]  guess_count;
   logic        busy, win, lose;

   int ncomp = 0;
   int nfail = 0;
   int exp_count;
   logic exp_win, exp_lose;

   wordle_guess_ctrl #(.MAX_GUESSES(MAX)) dut (
      .Clk(Clk), .reset(reset), .U(U), .D(D), .L(L), .R(R), .C(C),
      .answer(answer), .dict_req(dict_req), .dict_word(dict_word),
      .dict_ack(dict_ack), .dict_hit(dict_hit), .guess_word(guess_word),
      .cursor(cursor), .result(result), .result_valid(result_valid),
      .invalid_word(invalid_word), .guess_count(guess_count), .busy(busy),
      .win(win), .lose(lose)
   );

   always #5 Clk = ~Clk;

   function automatic logic [39:0] to_word(input string s);
      logic [39:0] w;
      for (int p = 0; p < 5; p++) w[p*8 +: 8] = s[p];
      return w;
   endfunction

   function automatic logic [39:0] all_a();
      return {5{8'h41}};
   endfunction

   function automatic logic [39:0] rand_word(input int k);
      logic [39:0] w;
      for (int p = 0; p < 5; p++) w[p*8 +: 8] = 8'h41 + 8'($urandom_range(0, k - 1));
      return w;
   endfunction

   // Reference scorer: exact matches consume answer letters first, then each
   // remaining guess letter, left to right, takes the leftmost unconsumed match.
   function automatic logic [9:0] model_score(input logic [39:0] g, input logic [39:0] a);
      byte gl[5];
      byte al[5];
      int  sc[5];
      bit  taken[5];
      logic [9:0] r;
      for (int p = 0; p < 5; p++) begin
         gl[p] = byte'(g[p*8 +: 8]);
         al[p] = byte'(a[p*8 +: 8]);
         sc[p] = 0;
         taken[p] = 0;
      end
      for (int p = 0; p < 5; p++)
         if (gl[p] == al[p]) begin sc[p] = 2; taken[p] = 1; end
      for (int p = 0; p < 5; p++) begin
         if (sc[p] == 0) begin
            for (int q = 0; q < 5; q++) begin
               if (sc[p] == 0 && !taken[q] && gl[p] == al[q]) begin
                  sc[p] = 1;
                  taken[q] = 1;
               end
            end
         end
      end
      r = '0;
      for (int p = 0; p < 5; p++) r[2*p +: 2] = 2'(sc[p]);
      return r;
   endfunction

   task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
      ncomp++;
      assert (obs === exp)
      else begin
         nfail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic press(input logic u, d, l, r, c);
      U = u; D = d; L = l; R = r; C = c;
      tick();
      U = 0; D = 0; L = 0; R = 0; C = 0;
   endtask

   task automatic chk_cleared(input string tag);
      chk({tag, "_guess"}, guess_word, all_a());
      chk({tag, "_cursor"}, 40'(cursor), 40'd0);
      chk({tag, "_result"}, 40'(result), 40'd0);
      chk({tag, "_rv"}, 40'(result_valid), 40'd0);
      chk({tag, "_count"}, 40'(guess_count), 40'd0);
      chk({tag, "_busy"}, 40'(busy), 40'd0);
      chk({tag, "_win"}, 40'(win), 40'd0);
      chk({tag, "_lose"}, 40'(lose), 40'd0);
      chk({tag, "_req"}, 40'(dict_req), 40'd0);
      chk({tag, "_inv"}, 40'(invalid_word), 40'd0);
   endtask

   task automatic start_game(input logic [39:0] ans);
      answer = ans;
      press(0, 0, 0, 0, 1);
      answer = '0;
      exp_count = 0;
      exp_win = 0;
      exp_lose = 0;
   endtask

   // Assumes the guess is all 'A' with the cursor at 0.
   task automatic type_word(input logic [39:0] w);
      int d;
      for (int p = 0; p < 5; p++) begin
         d = int'(w[p*8 +: 8]) - 'h41;
         if (d <= 13) repeat (d) press(1, 0, 0, 0, 0);
         else repeat (26 - d) press(0, 1, 0, 0, 0);
         press(0, 0, 0, 1, 0);
      end
      chk("typed_word", guess_word, w);
   endtask

   task automatic submit(input logic [39:0] ans, input logic [39:0] g, input logic udc);
      logic [9:0] er;
      int n;
      er = model_score(g, ans);
      press(udc, udc, 0, 0, 1);
      chk("submit_guess_frozen", guess_word, g);
`ifdef WORDLE_DICT_CHECK_EN
      chk("dict_req_rise", 40'(dict_req), 40'd1);
      chk("dict_word", dict_word, g);
      dict_ack = 1; dict_hit = 1;
      tick();
      dict_ack = 0; dict_hit = 0;
      chk("dict_req_drop", 40'(dict_req), 40'd0);
`else
      chk("dict_req_tied", 40'(dict_req), 40'd0);
`endif
      chk("busy_scoring", 40'(busy), 40'd1);
      n = 0;
      while (!result_valid && n < 60) begin
         tick();
         n++;
      end
      chk("report_latency", 40'(n), 40'd30);
      chk("result", 40'(result), 40'(er));
      exp_count++;
      exp_win  = (er == 10'b1010101010);
      exp_lose = !exp_win && (exp_count == MAX);
      chk("guess_count", 40'(guess_count), 40'(exp_count));
      chk("win", 40'(win), 40'(exp_win));
      chk("lose", 40'(lose), 40'(exp_lose));
      tick();
      chk("rv_one_cycle", 40'(result_valid), 40'd0);
      chk("busy_after", 40'(busy), 40'd0);
      chk("result_held", 40'(result), 40'(er));
      if (!exp_win && !exp_lose) begin
         chk("next_guess_reset", guess_word, all_a());
         chk("next_cursor_reset", 40'(cursor), 40'd0);
      end
   endtask

   initial begin
      logic [39:0] ans, g;
      int pulses;

      reset = 1; U = 0; D = 0; L = 0; R = 0; C = 0;
      answer = '0; dict_ack = 0; dict_hit = 0;
      exp_count = 0; exp_win = 0; exp_lose = 0;
      tick(); tick();
      chk_cleared("reset");
      reset = 0;
      tick();

      press(1, 0, 0, 0, 0);
      chk("idle_ignores_u", guess_word, all_a());

      // CRANE game: edit wrap/saturation, combined-button submit, then win
      ans = to_word("CRANE");
      start_game(ans);
      chk("game_start_busy", 40'(busy), 40'd0);
      press(0, 1, 0, 0, 0);
      chk("d_wrap_to_z", 40'(guess_word[7:0]), 40'h5A);
      press(1, 0, 0, 0, 0);
      chk("u_wrap_to_a", 40'(guess_word[7:0]), 40'h41);
      repeat (6) press(0, 0, 0, 1, 0);
      chk("cursor_sat_4", 40'(cursor), 40'd4);
      repeat (6) press(0, 0, 1, 0, 0);
      chk("cursor_sat_0", 40'(cursor), 40'd0);
      submit(ans, all_a(), 1'b1);
      type_word(ans);
      submit(ans, ans, 1'b0);
      chk("crane_all_green", 40'(result), 40'(10'b1010101010));
      press(1, 0, 0, 0, 0);
      chk("done_ignores_u", guess_word, ans);
      chk("done_holds_win", 40'(win), 40'd1);
      press(0, 0, 0, 0, 1);
      chk_cleared("done_to_idle");

      // APPLE game: duplicate-letter case, then lose on the sixth guess
      ans = to_word("APPLE");
      start_game(ans);
      g = to_word("PAPAL");
      type_word(g);
      submit(ans, g, 1'b0);
      chk("papal_score", 40'(result), 40'(10'b0100100101));
      for (int k = 0; k < 5; k++) begin
         g = rand_word(6);
         while (g == ans) g = rand_word(6);
         type_word(g);
         submit(ans, g, 1'b0);
      end
      chk("lose_count", 40'(guess_count), 40'd6);
      press(0, 0, 0, 0, 1);
      chk_cleared("lose_to_idle");

`ifdef WORDLE_DICT_CHECK_EN
      // Dictionary miss returns to editing with nothing counted
      ans = rand_word(26);
      start_game(ans);
      g = rand_word(26);
      type_word(g);
      press(0, 0, 0, 0, 1);
      chk("miss_req_rise", 40'(dict_req), 40'd1);
      repeat (3) tick();
      chk("miss_req_held", 40'(dict_req), 40'd1);
      dict_ack = 1; dict_hit = 0;
      #1;
      chk("miss_invalid_pulse", 40'(invalid_word), 40'd1);
      tick();
      dict_ack = 0;
      chk("miss_invalid_drop", 40'(invalid_word), 40'd0);
      chk("miss_busy", 40'(busy), 40'd0);
      chk("miss_count", 40'(guess_count), 40'd0);
      chk("miss_guess_kept", guess_word, g);
      chk("miss_cursor_kept", 40'(cursor), 40'd4);
      submit(ans, g, 1'b0);
      reset = 1; tick(); reset = 0; tick();
`endif

      // Random games over small alphabets so repeated letters are common
      for (int gm = 0; gm < 4; gm++) begin
         ans = rand_word(2 + (gm % 3));
         start_game(ans);
         while (!exp_win && !exp_lose) begin
            g = rand_word(2 + (gm % 3));
            type_word(g);
            submit(ans, g, 1'b0);
         end
         press(0, 0, 0, 0, 1);
         chk("rand_game_cleared", 40'(guess_count), 40'd0);
      end

      // Reset in the middle of the yellow pass
      ans = to_word("ABCDE");
      start_game(ans);
      type_word(to_word("EDCBA"));
      press(0, 0, 0, 0, 1);
      repeat (10) tick();
      chk("mid_yellow_busy", 40'(busy), 40'd1);
      #2 reset = 1;
      #1;
      chk_cleared("mid_yellow_reset");
      tick();
      reset = 0;
      pulses = 0;
      for (int k = 0; k < 40; k++) begin
         tick();
         if (result_valid) pulses++;
      end
      chk("no_partial_publish", 40'(pulses), 40'd0);
      chk("reset_result_zero", 40'(result), 40'd0);
      press(1, 0, 0, 0, 0);
      chk("post_reset_idle", guess_word, all_a());

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
      $finish;
   end

endmodule

// File: doc/wordle_guess_ctrl.md
# wordle_guess_ctrl

Sequencing controller for one Wordle game on the Nexys4 board. It turns debounced button pulses into a five-letter guess, optionally checks the guess against an external dictionary, and runs a fixed-latency two-pass scorer (green, then yellow) against the latched answer. It also tracks the guess count and reports win or lose. It sits between the button debouncers and the display/VGA datapath, and replaces ad-hoc guess-state stepping in the top-level state machine.

## Interface
- MAX_GUESSES, 6, guesses allowed before lose (1..7)
- ALPHA_FIRST, 8'h41, first legal letter ('A')
- ALPHA_LAST, 8'h5A, last legal letter ('Z')

Ports:
- Clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- U, D, L, R, C  in  1 each  single-cycle debounced button pulses
- answer  in  40  answer word, ASCII, [7:0] = position 0; sampled when a game starts
- dict_req  out  1  dictionary lookup request
- dict_word  out  40  word under lookup (equals guess_word)
- dict_ack  in  1  lookup complete
- dict_hit  in  1  word found; valid only with dict_ack
- guess_word  out  40  letters being edited
- cursor  out  3  edit position, 0..4
- result  out  10  per-position score, [1:0] = position 0: 00 gray, 01 yellow, 10 green
- result_valid  out  1  one-cycle pulse when result is updated
- invalid_word  out  1  one-cycle pulse on a dictionary miss
- guess_count  out  3  scored guesses this game
- busy  out  1  high in DICT, GREEN, YELLOW and REPORT
- win, lose  out  1 each  game outcome, registered

## Operation
- Reset values:
  - state IDLE
  - guess_word all 8'h41
  - cursor 0, result 0, guess_count 0
  - all pulses, dict_req, busy, win and lose 0
- IDLE: on C, latch answer, clear result, guess_count, win and lose, then go to EDIT.
- EDIT: one button acts per cycle, priority C > U > D > L > R.
  - U increments the letter at cursor; Z wraps to A.
  - D decrements the letter at cursor; A wraps to Z.
  - R increments cursor, saturating at 4. L decrements cursor, saturating at 0.
  - C submits the guess.
- DICT (only with the macro):
  - dict_req is held high until dict_ack.
  - Hit: go to GREEN.
  - Miss: pulse invalid_word and return to EDIT. guess_word, cursor and guess_count are unchanged.
- GREEN: 5 cycles, index i = 0..4.
  - When guess[i] == answer[i], mark green and set ans_used[i].
- YELLOW: 25 cycles, i outer, j inner, every pair visited.
  - For non-green i, take the first j (ascending) with guess[i] == answer[j] and ans_used[j] clear.
  - Mark i yellow and set ans_used[j]; later j for that i are ignored.
- REPORT: 1 cycle.
  - Write result, pulse result_valid, increment guess_count.
  - All green: go to DONE with win = 1.
  - Else if guess_count reaches MAX_GUESSES: go to DONE with lose = 1.
  - Else: go to EDIT with guess_word reset to all 'A' and cursor 0.
- DONE: win/lose hold; on C go to IDLE.
- Buttons are ignored everywhere except EDIT, and except C in IDLE and DONE.
- A reset asserted mid-game, including mid-score, returns all outputs to their reset values on the next edge; no partial result is ever published.

## Timing
- C accepted in EDIT at cycle t, without the macro:
  - GREEN occupies t+1..t+5.
  - YELLOW occupies t+6..t+30.
  - result_valid and the new result appear at t+31.
  - The new state (EDIT or DONE) takes effect at t+32.
- With the macro, the same schedule starts the cycle after dict_ack is sampled high.
  - dict_req rises at t+1.
  - An ack arriving in the same cycle req rises is legal.
- result holds until the next REPORT or the next game start.
- win and lose rise together with that REPORT's result_valid.

## Configuration
- WORDLE_DICT_CHECK_EN
  - Defined: DICT state is present, and the dict_* handshake and invalid_word are live.
  - Undefined: C goes directly to GREEN, dict_req and invalid_word are tied to 0, and dict_ack and dict_hit are ignored.

## Structure
- Shared package wordle_pkg holds:
  - state enum
  - letter constants (ALPHA_FIRST, ALPHA_LAST)
  - result codes (GRAY, YELLOW, GREEN)
  - a 40-bit word typedef
- One sub-module, wordle_scorer, holds the GREEN/YELLOW indices, the ans_used flags and the result register. It has a start/done handshake; the controller owns editing, the dictionary handshake and game accounting.

## Test plan
- Answer "CRANE", guess "CRANE" -> result 10_10_10_10_10 at t+31, win = 1, guess_count = 1, state DONE.
- Answer "APPLE", guess "PAPAL" -> pos0..4 = Y, Y, G, X, Y. The second A must score gray.
- Edit wrap and saturation after start:
  - D -> guess_word[7:0] = 'Z'; then U -> 'A'.
  - Six R -> cursor = 4; five L plus one extra L -> cursor = 0.
  - U, D and C asserted together -> submit only.
- Six non-winning guesses -> sixth REPORT sets lose = 1, guess_count = 6. C -> IDLE with all outputs cleared.
- With WORDLE_DICT_CHECK_EN:
  - dict_ack with hit = 0 after 3 cycles -> invalid_word pulse, back to EDIT, guess_count unchanged.
  - Hit -> result_valid exactly 31 cycles after the ack cycle.
- reset asserted during YELLOW -> state IDLE, result = 0, result_valid never pulses.
